// File: rtl/uart_frame_scheduler.sv
// Round-robin framer sharing one UART transmitter across CH_NUM ADC FIFOs.
// Frame: HEADER, channel id, FRAME_LEN samples, 8-bit additive checksum.
module uart_frame_scheduler #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned FRAME_LEN = 64,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic [8*CH_NUM-1:0] ch_data,
    input  logic [CH_NUM-1:0]   ch_rdempty,
    input  logic [CH_NUM-1:0]   ch_enable,
    output logic [CH_NUM-1:0]   ch_rdreq,
    output logic [7:0]          uart_data,
    output logic                send_en,
    input  logic                tx_done,
    output logic [2:0]          cur_ch,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned   CW       = 3;
    localparam int unsigned   NW       = 8;
    localparam logic [CW-1:0] LAST_RST = CW'(CH_NUM - 1);
    localparam logic [NW-1:0] N_LAST   = NW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {S_SEL, S_HDR, S_CHID, S_DATA, S_SUM, S_FIN} state_t;
    typedef enum logic [1:0] {P_LOAD, P_ARM, P_WAIT} phase_t;

    state_t          r_state;
    phase_t          r_phase;
    logic [CW-1:0]   r_last_ch;
    logic [CW-1:0]   r_cur_ch;
    logic [NW-1:0]   r_n;
    logic [7:0]      r_sum;
    logic [7:0]      r_uart_data;
    logic            r_send_en;
    logic [CH_NUM-1:0] r_rdreq;
    logic            r_busy;
    logic            r_frame_done;

    logic            w_found;
    logic [CW-1:0]   w_sel_ch;
    logic [7:0]      w_cur_data;
    logic            w_cur_empty;
    logic            w_cur_en;
    logic            w_byte_done;

    // First enabled, non-empty channel after the last one served
    always_comb begin
        w_found  = 1'b0;
        w_sel_ch = '0;
        for (int i = 1; i <= int'(CH_NUM); i++) begin
            for (int k = 0; k < int'(CH_NUM); k++) begin
                if (!w_found && (k == (int'(r_last_ch) + i) % int'(CH_NUM)) &&
                    ch_enable[k] && !ch_rdempty[k]) begin
                    w_found  = 1'b1;
                    w_sel_ch = CW'(k);
                end
            end
        end
    end

    // View of the channel currently being framed
    always_comb begin
        w_cur_data  = '0;
        w_cur_empty = 1'b1;
        w_cur_en    = 1'b0;
        for (int k = 0; k < int'(CH_NUM); k++) begin
            if (CW'(k) == r_cur_ch) begin
                w_cur_data  = ch_data[8*k +: 8];
                w_cur_empty = ch_rdempty[k];
                w_cur_en    = ch_enable[k];
            end
        end
    end

    assign w_byte_done = (r_phase == P_WAIT) && r_send_en && tx_done;

    // Frame sequencer; r_phase runs the load / raise / wait-done handshake of each byte
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_SEL;
            r_phase      <= P_LOAD;
            r_last_ch    <= LAST_RST;
            r_cur_ch     <= '0;
            r_n          <= '0;
            r_sum        <= '0;
            r_uart_data  <= '0;
            r_send_en    <= 1'b0;
            r_rdreq      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rdreq      <= '0;
            r_frame_done <= 1'b0;

            case (r_phase)
                P_ARM: begin
                    r_send_en <= 1'b1;
                    r_phase   <= P_WAIT;
                end
                P_WAIT: begin
                    if (w_byte_done) begin
                        r_send_en <= 1'b0;
                        r_phase   <= P_LOAD;
                    end
                end
                default: ;
            endcase

            case (r_state)
                S_SEL: begin
                    if (w_found) begin
                        r_cur_ch  <= w_sel_ch;
                        r_last_ch <= w_sel_ch;
                        r_busy    <= 1'b1;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (r_phase == P_LOAD) begin
                        r_uart_data <= HEADER;
                        r_phase     <= P_ARM;
                    end else if (w_byte_done) begin
                        r_state <= S_CHID;
                    end
                end
                S_CHID: begin
                    if (r_phase == P_LOAD) begin
                        r_uart_data <= {5'b0, r_cur_ch};
                        r_sum       <= {5'b0, r_cur_ch};
                        r_phase     <= P_ARM;
                    end else if (w_byte_done) begin
                        r_n     <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_phase == P_LOAD) begin
                        // A disabled channel pads with zeros and never pops
                        if (!w_cur_en) begin
                            r_uart_data <= 8'h00;
                            r_phase     <= P_ARM;
                        end else if (!w_cur_empty) begin
                            r_uart_data <= w_cur_data;
                            r_rdreq     <= CH_NUM'(1) << r_cur_ch;
                            r_phase     <= P_ARM;
                        end
                    end else if (w_byte_done) begin
                        r_sum <= r_sum + r_uart_data;
                        if (r_n == N_LAST) begin
                            r_n     <= '0;
                            r_state <= S_SUM;
                        end else begin
                            r_n <= r_n + 8'd1;
                        end
                    end
                end
                S_SUM: begin
                    if (r_phase == P_LOAD) begin
                        r_uart_data <= r_sum;
                        r_phase     <= P_ARM;
                    end else if (w_byte_done) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_SEL;
                end
                default: r_state <= S_SEL;
            endcase
        end
    end

    assign ch_rdreq   = r_rdreq;
    assign uart_data  = r_uart_data;
    assign send_en    = r_send_en;
    assign cur_ch     = r_cur_ch;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Bench for uart_frame_scheduler: behavioural FIFOs and UART, frame-level round-robin reference.
module tb_uart_frame_scheduler;
    localparam int unsigned CH  = 4;
    localparam int unsigned FL  = 3;
    localparam logic [7:0]  HDR = 8'hA5;

    logic            Clk        = 1'b0;
    logic            Reset_n    = 1'b1;
    logic [8*CH-1:0] ch_data    = '0;
    logic [CH-1:0]   ch_rdempty = '1;
    logic [CH-1:0]   ch_enable  = '0;
    logic [CH-1:0]   ch_rdreq;
    logic [7:0]      uart_data;
    logic            send_en;
    logic            tx_done    = 1'b0;
    logic [2:0]      cur_ch;
    logic            busy;
    logic            frame_done;

    uart_frame_scheduler #(.CH_NUM(CH), .FRAME_LEN(FL), .HEADER(HDR)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ch_data(ch_data), .ch_rdempty(ch_rdempty),
        .ch_enable(ch_enable), .ch_rdreq(ch_rdreq), .uart_data(uart_data),
        .send_en(send_en), .tx_done(tx_done), .cur_ch(cur_ch), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 Clk = ~Clk;

    logic [7:0] fq [CH][$];
    logic [7:0] got[$];
    logic [7:0] exp_b[$];
    int         got_ord[$];
    int         exp_ord[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_rdreq = 0;
    int         n_fd = 0;
    int         stall_bad = 0;
    logic       stall_mon = 1'b0;
    int         dly = 0;
    logic [7:0] held = '0;
    logic       prev_se = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // FIFO + UART models, evaluated on the falling edge
    initial begin
        forever begin
            @(negedge Clk);
            if (ch_rdreq != '0) begin
                n_rdreq++;
                chk("rdreq_onehot", 32'($onehot(ch_rdreq)), 32'd1);
                for (int k = 0; k < CH; k++) begin
                    if (ch_rdreq[k]) begin
                        chk("rdreq_nonempty", 32'(fq[k].size() != 0), 32'd1);
                        if (fq[k].size() != 0) fq[k].delete(0);
                    end
                end
            end
            if (stall_mon && (send_en || ch_rdreq != '0)) stall_bad++;
            if (frame_done) begin
                n_fd++;
                got_ord.push_back(int'(cur_ch));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (tx_done) begin
                tx_done = 1'b0;
            end else if (send_en) begin
                if (!prev_se) begin
                    held = uart_data;
                    dly  = int'($urandom_range(1, 6));
                end
                if (dly == 0) begin
                    chk("data_stable", 32'(uart_data), 32'(held));
                    got.push_back(uart_data);
                    tx_done = 1'b1;
                end else begin
                    dly--;
                end
            end
            prev_se = send_en;
            for (int k = 0; k < CH; k++) begin
                ch_rdempty[k]     = (fq[k].size() == 0);
                ch_data[8*k +: 8] = (fq[k].size() != 0) ? fq[k][0] : 8'h00;
            end
        end
    end

    task automatic clear_env();
        ch_enable = '0;
        for (int k = 0; k < CH; k++) fq[k].delete();
        got.delete();
        got_ord.delete();
        exp_b.delete();
        exp_ord.delete();
        n_rdreq   = 0;
        n_fd      = 0;
        stall_bad = 0;
        stall_mon = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        clear_env();
        @(negedge Clk);
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Frame-level reference: round robin over enabled, non-empty queues from ch0 priority
    task automatic build_exp();
        logic [7:0] mq [CH][$];
        int         last;
        int         c;
        logic [7:0] s;
        exp_b.delete();
        exp_ord.delete();
        for (int k = 0; k < CH; k++) mq[k] = fq[k];
        last = CH - 1;
        for (int f = 0; f < 64; f++) begin
            c = -1;
            for (int i = 1; i <= CH; i++) begin
                if (c < 0 && ch_enable[(last + i) % CH] && mq[(last + i) % CH].size() >= FL)
                    c = (last + i) % CH;
            end
            if (c < 0) break;
            exp_ord.push_back(c);
            exp_b.push_back(HDR);
            s = 8'(c);
            exp_b.push_back(8'(c));
            for (int j = 0; j < FL; j++) begin
                s = s + mq[c][0];
                exp_b.push_back(mq[c].pop_front());
            end
            exp_b.push_back(s);
            last = c;
        end
    endtask

    task automatic wait_frames(input string tag, input int n);
        int cyc = 0;
        while (n_fd < n && cyc < 20000) begin
            @(negedge Clk);
            cyc++;
        end
        chk({tag, "_frames_done"}, 32'(n_fd), 32'(n));
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int cyc = 0;
        while (got.size() < n && cyc < 5000) begin
            @(negedge Clk);
            cyc++;
        end
        chk({tag, "_bytes_seen"}, 32'(got.size() >= n), 32'd1);
    endtask

    task automatic cmp_frames(input string tag);
        chk({tag, "_nbytes"}, 32'(got.size()), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_b[i]));
        chk({tag, "_nframes"}, 32'(got_ord.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size() && i < got_ord.size(); i++)
            chk($sformatf("%s_ch%0d", tag, i), 32'(got_ord[i]), 32'(exp_ord[i]));
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int         nfr;

        #1 Reset_n = 1'b0;
        #2 chk("reset_outputs", 32'({ch_rdreq, uart_data, send_en, cur_ch, busy, frame_done}), 32'd0);

        // Single channel, fixed data 0A,14,1E
        do_reset();
        ch_enable = 4'b0001;
        fq[0].push_back(8'h0A); fq[0].push_back(8'h14); fq[0].push_back(8'h1E);
        build_exp();
        release_reset();
        wait_frames("s1", 1);
        cmp_frames("s1");
        chk("s1_rdreq_count", 32'(n_rdreq), 32'd3);
        if (got.size() == 6) chk("s1_checksum", 32'(got[5]), 32'h3C);
        repeat (30) @(negedge Clk);
        chk("s1_idle_after", 32'({busy, send_en, n_fd[7:0]}), 32'd1);

        // All channels busy: rotation 0,1,2,3,0
        do_reset();
        ch_enable = 4'b1111;
        for (int k = 0; k < CH; k++)
            for (int j = 0; j < ((k == 0) ? 2 * FL : FL); j++) fq[k].push_back(8'($urandom));
        build_exp();
        release_reset();
        wait_frames("s2", 5);
        cmp_frames("s2");

        // Mid-frame FIFO underrun stalls silently, then resumes
        do_reset();
        ch_enable = 4'b0001;
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        fq[0].push_back(r0);
        release_reset();
        wait_bytes("s3_pre", 3);
        repeat (3) @(negedge Clk);
        stall_mon = 1'b1;
        repeat (200) @(negedge Clk);
        stall_mon = 1'b0;
        chk("s3_stall_quiet", 32'(stall_bad), 32'd0);
        chk("s3_stall_rdreq", 32'(n_rdreq), 32'd1);
        fq[0].push_back(r1); fq[0].push_back(r2);
        exp_b = '{HDR, 8'h00, r0, r1, r2, 8'(r0 + r1 + r2)};
        exp_ord = '{0};
        wait_frames("s3", 1);
        cmp_frames("s3");

        // Channel disabled after two samples: zero padding, no more pops
        do_reset();
        ch_enable = 4'b0100;
        r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
        fq[2].push_back(r0); fq[2].push_back(r1); fq[2].push_back(r2);
        release_reset();
        wait_bytes("s4_pre", 4);
        ch_enable = 4'b0000;
        exp_b = '{HDR, 8'h02, r0, r1, 8'h00, 8'(8'h02 + r0 + r1)};
        exp_ord = '{2};
        wait_frames("s4", 1);
        cmp_frames("s4");
        chk("s4_rdreq_count", 32'(n_rdreq), 32'd2);

        // Checksum wrap with all-ones samples
        do_reset();
        ch_enable = 4'b0010;
        repeat (FL) fq[1].push_back(8'hFF);
        build_exp();
        release_reset();
        wait_frames("s5", 1);
        cmp_frames("s5");
        if (got.size() == 6) chk("s5_checksum", 32'(got[5]), 32'hFE);

        // Reset mid-DATA: immediate clear, then ch0 priority again
        do_reset();
        ch_enable = 4'b0010;
        repeat (FL) fq[1].push_back(8'($urandom));
        release_reset();
        wait_bytes("s6_pre", 3);
        #2 Reset_n = 1'b0;
        #1 chk("s6_async_clear", 32'({ch_rdreq, uart_data, send_en, cur_ch, busy, frame_done}), 32'd0);
        @(negedge Clk);
        clear_env();
        @(negedge Clk);
        ch_enable = 4'b0011;
        repeat (FL) fq[0].push_back(8'($urandom));
        repeat (FL) fq[1].push_back(8'($urandom));
        build_exp();
        release_reset();
        wait_frames("s6", 2);
        cmp_frames("s6");
        if (got_ord.size() > 0) chk("s6_first_ch", 32'(got_ord[0]), 32'd0);

        // Random enables and FIFO depths
        for (int it = 0; it < 8; it++) begin
            do_reset();
            ch_enable = 4'($urandom_range(1, 15));
            for (int k = 0; k < CH; k++) begin
                nfr = int'($urandom_range(0, 2));
                repeat (nfr * FL) fq[k].push_back(8'($urandom));
            end
            build_exp();
            release_reset();
            wait_frames($sformatf("rnd%0d", it), exp_ord.size());
            repeat (20) @(negedge Clk);
            cmp_frames($sformatf("rnd%0d", it));
            chk($sformatf("rnd%0d_idle", it), 32'({busy, send_en}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
- Round-robin scheduler that shares the single UART transmitter between CH_NUM ADC channel FIFOs.
- For the selected channel it emits one framed packet: header, channel id, FRAME_LEN samples, checksum. It then moves to the next channel.
- Sits between the per-channel ADC FIFO read ports and the Uart block's Data/send_en/tx_done handshake.
- Replaces single-channel ad-hoc read/send glue in the top level.

Parameters:
CH_NUM, 4, number of ADC channel FIFOs (2..8)
FRAME_LEN, 64, samples per frame (1..255)
HEADER, 8'hA5, first byte of every frame

Ports:
Clk  in  1  system clock; FIFO read clock and UART clock
Reset_n  in  1  asynchronous active-low reset
ch_data  in  8*CH_NUM  show-ahead FIFO outputs; channel k at bits [8k+7:8k]
ch_rdempty  in  CH_NUM  FIFO empty flags
ch_enable  in  CH_NUM  channel enabled for scheduling
ch_rdreq  out  CH_NUM  FIFO pop, one-hot, 1-cycle pulses
uart_data  out  8  byte to Uart Data
send_en  out  1  to Uart send_en
tx_done  in  1  Uart 1-cycle byte-complete pulse
cur_ch  out  3  channel currently being framed
busy  out  1  high while a frame is in progress
frame_done  out  1  1-cycle pulse after checksum byte completes

Behaviour:
- Reset (async, Reset_n=0) clears all outputs to 0 and sets the state to SEL. last_ch resets to CH_NUM-1, so ch0 has first priority.
- FIFO semantics:
  - ch_data[k] is valid whenever ch_rdempty[k]=0.
  - A 1-cycle ch_rdreq[k] pops that word at the same edge the byte is latched into uart_data.
  - Never pulse rdreq on an empty FIFO.
- Byte handshake, used for every byte:
  - Load uart_data, then raise send_en on the next cycle.
  - Hold uart_data and send_en stable until tx_done=1 is sampled.
  - Drop send_en on the following edge.
  - Keep send_en low for at least 1 cycle before the next byte.
  - Ignore tx_done while send_en=0.
- States:
  - SEL: search channels last_ch+1 … last_ch+CH_NUM modulo CH_NUM. The first k with ch_enable[k]=1 and ch_rdempty[k]=0 wins: cur_ch<=k, last_ch<=k, busy<=1, go to HDR. If none qualify, stay in SEL with busy=0. The search is combinational and takes 1 cycle.
  - HDR: send HEADER, then go to CHID.
  - CHID: send {5'b0,cur_ch}. The checksum accumulator sum is initialised to that byte.
  - DATA:
    - sample counter n runs 0..FRAME_LEN-1.
    - For each sample, wait while ch_rdempty[cur_ch]=1 (send_en stays low).
    - When data is available, latch it and pop.
    - After the byte is sent, sum<=sum+byte (mod 256) and n<=n+1.
    - After FRAME_LEN bytes, go to SUM.
  - SUM: send sum. On the edge after its send_en drops, pulse frame_done, set busy<=0 and go to SEL.
- Disable mid-frame: if ch_enable[cur_ch] falls during DATA, the remaining samples are sent as 8'h00 with no pops and no waiting on empty. The frame length is always FRAME_LEN+3 bytes.
- A byte already handed to the UART is never aborted. ch_enable changes affect only subsequent byte decisions.
- Frames never overlap. last_ch advances once per frame, so each enabled, non-empty channel is served at least once every CH_NUM frames.
- An empty FIFO mid-frame stalls indefinitely with no timeout; bytes are never duplicated or skipped.
- Reset mid-frame aborts immediately with no padding: send_en=0, no rdreq.

Test Plan:
- Reset, ch0 only enabled with 3 words in FIFO, FRAME_LEN=3, data 10,20,30:
  - UART sees A5,00,0A,14,1E,3C.
  - exactly 3 rdreq pulses; frame_done once.
- All 4 channels enabled and non-empty, FRAME_LEN=2:
  - cur_ch order is 0,1,2,3,0.
  - channel id bytes are 00,01,02,03,00.
- FIFO empties after sample 1 of 4 for 200 cycles, then refills:
  - send_en stays low during the stall.
  - no rdreq during the stall.
  - the frame resumes and completes with 4 samples and the correct checksum.
- ch_enable[cur_ch] deasserted after 2 of 5 samples on ch2:
  - remaining 3 bytes are 00.
  - no further rdreq; checksum = 02 + s0 + s1.
- Sample bytes FF,FF,FF on ch1:
  - checksum (01+FF+FF+FF) mod 256 = FE.
- Reset_n pulsed low mid-DATA:
  - all outputs are 0 within the same cycle.
  - after release, the next frame starts from ch0 priority.
